// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants for the DES key schedule: the PC-1 and PC-2 selection
// tables (FIPS 46 1-based bit numbers), the per-round left-rotation schedule,
// and a few helpers used to build the rotations at elaboration time.
// No ports (package).
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int KEY_W  = 64;
  localparam int CD_W   = 56;
  localparam int HALF_W = 28;
  localparam int RK_W   = 48;
  localparam int ROUNDS = 16;

  // PC-1: output bit i (1-based, MSB first) takes key bit PC1[i-1].
  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: subkey bit i (1-based, MSB first) takes C||D bit PC2[i-1].
  localparam int PC2 [RK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_SCHEDULE [ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // Total rotation applied to C0/D0 to reach round r (0-based), so every
  // round can be derived directly from C0/D0 instead of chaining rotators.
  function automatic int cum_shift(input int r);
    int s;
    s = 0;
    for (int i = 0; i <= r; i++) s += SHIFT_SCHEDULE[i];
    return s;
  endfunction

  // 28-bit left rotate; n in 1..28 (n = 28 is the identity).
  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] v,
                                               input int n);
    return (v << n) | (v >> (HALF_W - n));
  endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// DES Permuted Choice 2: selects 48 of the 56 C||D bits to form one round
// subkey. Pure combinational wiring.
// Ports:
//   cd_in  [55:0]  C||D, FIPS bit 1 at [55]
//   k_out  [47:0]  subkey, FIPS bit 1 at [47]
// -----------------------------------------------------------------------------
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd_in,
  output logic [RK_W-1:0] k_out
);

  for (genvar g = 0; g < RK_W; g++) begin : g_sel
    localparam int SRC = CD_W - PC2[g];
    assign k_out[RK_W-1-g] = cd_in[SRC];
  end

  // PC-2 drops C||D bits 9, 18, 22, 25, 35, 38, 43 and 54.
  logic unused_cd;
  assign unused_cd = ^{cd_in[CD_W-9],  cd_in[CD_W-18], cd_in[CD_W-22],
                       cd_in[CD_W-25], cd_in[CD_W-35], cd_in[CD_W-38],
                       cd_in[CD_W-43], cd_in[CD_W-54]};

endmodule

// File: rtl/key_schedule.sv
// -----------------------------------------------------------------------------
// key_schedule
// DES key schedule: expands one 64-bit key into all 16 round subkeys in one
// cycle. PC-1 and the rotations are combinational; the subkeys are captured
// into output registers on each key_valid edge.
// Parameter:
//   REVERSE_ORDER  0: round_keyN = K(N+1) (encrypt); 1: round_keyN = K(16-N)
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   key_in [63:0]  DES key, FIPS bit 1 at [63]; parity bits not used by schedule
//   key_valid      load strobe
//   keys_valid     high for one cycle after each load
//   parity_err     (only with KEY_SCHEDULE_PARITY_CHECK_EN) a key byte at load
//                  time had even parity
//   round_key0..15 [47:0] round subkeys, FIPS bit 1 at [47]
// Build option: define KEY_SCHEDULE_PARITY_CHECK_EN to add parity_err.
// -----------------------------------------------------------------------------
module key_schedule
  import des_pkg::*;
#(
  parameter int REVERSE_ORDER = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [63:0]     key_in,
  input  logic            key_valid,
  output logic            keys_valid,
`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
  output logic            parity_err,
`endif
  output logic [47:0]     round_key0,
  output logic [47:0]     round_key1,
  output logic [47:0]     round_key2,
  output logic [47:0]     round_key3,
  output logic [47:0]     round_key4,
  output logic [47:0]     round_key5,
  output logic [47:0]     round_key6,
  output logic [47:0]     round_key7,
  output logic [47:0]     round_key8,
  output logic [47:0]     round_key9,
  output logic [47:0]     round_key10,
  output logic [47:0]     round_key11,
  output logic [47:0]     round_key12,
  output logic [47:0]     round_key13,
  output logic [47:0]     round_key14,
  output logic [47:0]     round_key15
);

  // ---- stage p0: PC-1, rotations, PC-2 (combinational) ----
  logic [CD_W-1:0]   cd0_p0;
  logic [HALF_W-1:0] c0_p0;
  logic [HALF_W-1:0] d0_p0;
  logic [CD_W-1:0]   cd_p0  [ROUNDS];
  logic [RK_W-1:0]   sub_p0 [ROUNDS];

  for (genvar g = 0; g < CD_W; g++) begin : g_pc1
    localparam int SRC = KEY_W - PC1[g];
    assign cd0_p0[CD_W-1-g] = key_in[SRC];
  end

  assign c0_p0 = cd0_p0[CD_W-1:HALF_W];
  assign d0_p0 = cd0_p0[HALF_W-1:0];

  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    localparam int SH = cum_shift(r);
    assign cd_p0[r] = {rotl28(c0_p0, SH), rotl28(d0_p0, SH)};
    des_pc2 u_pc2 (
      .cd_in (cd_p0[r]),
      .k_out (sub_p0[r])
    );
  end

  // ---- stage p1: output registers ----
  logic [RK_W-1:0] rk_p1 [ROUNDS];
  logic            vld_p1;

  for (genvar g = 0; g < ROUNDS; g++) begin : g_out
    localparam int SRC = (REVERSE_ORDER != 0) ? (ROUNDS - 1 - g) : g;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rk_p1[g] <= '0;
      end else if (key_valid) begin
        rk_p1[g] <= sub_p0[SRC];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= key_valid;
    end
  end

`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
  // DES expects odd parity in every byte; an even-parity byte is an error.
  logic par_bad_p0;
  logic par_err_p1;

  assign par_bad_p0 = ~(^key_in[63:56]) | ~(^key_in[55:48]) |
                      ~(^key_in[47:40]) | ~(^key_in[39:32]) |
                      ~(^key_in[31:24]) | ~(^key_in[23:16]) |
                      ~(^key_in[15:8])  | ~(^key_in[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_p1 <= 1'b0;
    end else if (key_valid) begin
      par_err_p1 <= par_bad_p0;
    end
  end

  assign parity_err = par_err_p1;
`else
  // Parity bits 8, 16, ..., 64 are not selected by PC-1.
  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};
`endif

  assign keys_valid  = vld_p1;
  assign round_key0  = rk_p1[0];
  assign round_key1  = rk_p1[1];
  assign round_key2  = rk_p1[2];
  assign round_key3  = rk_p1[3];
  assign round_key4  = rk_p1[4];
  assign round_key5  = rk_p1[5];
  assign round_key6  = rk_p1[6];
  assign round_key7  = rk_p1[7];
  assign round_key8  = rk_p1[8];
  assign round_key9  = rk_p1[9];
  assign round_key10 = rk_p1[10];
  assign round_key11 = rk_p1[11];
  assign round_key12 = rk_p1[12];
  assign round_key13 = rk_p1[13];
  assign round_key14 = rk_p1[14];
  assign round_key15 = rk_p1[15];

endmodule

// File: tb/tb_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_key_schedule
// Directed bench for key_schedule: one instance in encryption order, one in
// decryption order, both driven by the same key/strobe.
// -----------------------------------------------------------------------------
module tb_key_schedule;

  logic        clk;
  logic        rst_n;
  logic [63:0] key_in;
  logic        key_valid;
  logic        kv_f, kv_r;
  logic [47:0] rk [16];
  logic [47:0] rr [16];
`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
  logic        perr_f, perr_r;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] KEY_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_B = 64'h133457799BBCDFF1;

  key_schedule #(.REVERSE_ORDER(0)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .keys_valid(kv_f),
`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
    .parity_err(perr_f),
`endif
    .round_key0(rk[0]),   .round_key1(rk[1]),   .round_key2(rk[2]),
    .round_key3(rk[3]),   .round_key4(rk[4]),   .round_key5(rk[5]),
    .round_key6(rk[6]),   .round_key7(rk[7]),   .round_key8(rk[8]),
    .round_key9(rk[9]),   .round_key10(rk[10]), .round_key11(rk[11]),
    .round_key12(rk[12]), .round_key13(rk[13]), .round_key14(rk[14]),
    .round_key15(rk[15])
  );

  key_schedule #(.REVERSE_ORDER(1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .keys_valid(kv_r),
`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
    .parity_err(perr_r),
`endif
    .round_key0(rr[0]),   .round_key1(rr[1]),   .round_key2(rr[2]),
    .round_key3(rr[3]),   .round_key4(rr[4]),   .round_key5(rr[5]),
    .round_key6(rr[6]),   .round_key7(rr[7]),   .round_key8(rr[8]),
    .round_key9(rr[9]),   .round_key10(rr[10]), .round_key11(rr[11]),
    .round_key12(rr[12]), .round_key13(rr[13]), .round_key14(rr[14]),
    .round_key15(rr[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_rk%0d", tag, i), {16'h0, rk[i]}, 64'h0);
      chk($sformatf("%s_rr%0d", tag, i), {16'h0, rr[i]}, 64'h0);
    end
  endtask

  // One-cycle load strobe; returns #1 after the capturing edge.
  task automatic load(input logic [63:0] k);
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_in    = 64'h0;
    key_valid = 1'b0;

    // reset state
    #12;
    chk("rst_kv", {63'h0, kv_f}, 64'h0);
    chk("rst_kv_rev", {63'h0, kv_r}, 64'h0);
    chk_all_zero("rst");
`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
    chk("rst_perr", {63'h0, perr_f}, 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // vector A, both orders
    load(KEY_A);
    chk("A_kv", {63'h0, kv_f}, 64'h1);
    chk("A_rk0", {16'h0, rk[0]}, {16'h0, 48'h0B02679B49A5});
    chk("A_rk1", {16'h0, rk[1]}, {16'h0, 48'h69A659256A26});
    chk("A_rk7", {16'h0, rk[7]}, {16'h0, 48'h5788386CE581});
    chk("A_rk15", {16'h0, rk[15]}, {16'h0, 48'hCA3D03B87032});
    chk("A_rev_kv", {63'h0, kv_r}, 64'h1);
    chk("A_rev_rr0", {16'h0, rr[0]}, {16'h0, 48'hCA3D03B87032});
    chk("A_rev_rr8", {16'h0, rr[8]}, {16'h0, 48'h5788386CE581});
    chk("A_rev_rr15", {16'h0, rr[15]}, {16'h0, 48'h0B02679B49A5});
`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
    chk("A_perr", {63'h0, perr_f}, 64'h0);
`endif
    @(posedge clk);
    #1;
    chk("A_kv_drop", {63'h0, kv_f}, 64'h0);

    // FIPS example key
    load(KEY_B);
    chk("B_kv", {63'h0, kv_f}, 64'h1);
    chk("B_rk0", {16'h0, rk[0]}, {16'h0, 48'h1B02EFFC7072});
    chk("B_rk15", {16'h0, rk[15]}, {16'h0, 48'hCB3D8B0E17F5});
    chk("B_rev_rr0", {16'h0, rr[0]}, {16'h0, 48'hCB3D8B0E17F5});

    // all-zero key
    load(64'h0);
    chk("Z_kv", {63'h0, kv_f}, 64'h1);
    chk_all_zero("Z");
`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
    chk("Z_perr", {63'h0, perr_f}, 64'h1);
`endif

    // hold: key changes with strobe low must not disturb the outputs
    load(KEY_A);
    key_in = KEY_B;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("H%0d_kv", c), {63'h0, kv_f}, 64'h0);
      chk($sformatf("H%0d_rk0", c), {16'h0, rk[0]}, {16'h0, 48'h0B02679B49A5});
      chk($sformatf("H%0d_rk15", c), {16'h0, rk[15]}, {16'h0, 48'hCA3D03B87032});
    end
`ifdef KEY_SCHEDULE_PARITY_CHECK_EN
    chk("H_perr", {63'h0, perr_f}, 64'h0);
`endif
    // asynchronous reset mid-hold, well away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("HR");
    chk("HR_kv", {63'h0, kv_f}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // first load after reset release, then reset while keys_valid is high
    load(KEY_A);
    chk("PR_kv", {63'h0, kv_f}, 64'h1);
    chk("PR_rk0", {16'h0, rk[0]}, {16'h0, 48'h0B02679B49A5});
    rst_n = 1'b0;
    #1;
    chk("VR_kv", {63'h0, kv_f}, 64'h0);
    chk("VR_rk0", {16'h0, rk[0]}, 64'h0);
    chk("VR_rr0", {16'h0, rr[0]}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back loads with the strobe held high
    @(negedge clk);
    key_in    = KEY_A;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("BB1_kv", {63'h0, kv_f}, 64'h1);
    chk("BB1_rk0", {16'h0, rk[0]}, {16'h0, 48'h0B02679B49A5});
    key_in = KEY_B;
    @(posedge clk);
    #1;
    chk("BB2_kv", {63'h0, kv_f}, 64'h1);
    chk("BB2_rk0", {16'h0, rk[0]}, {16'h0, 48'h1B02EFFC7072});
    chk("BB2_rk15", {16'h0, rk[15]}, {16'h0, 48'hCB3D8B0E17F5});
    key_valid = 1'b0;
    key_in    = 64'h0;
    @(posedge clk);
    #1;
    chk("BB3_kv", {63'h0, kv_f}, 64'h0);
    chk("BB3_rk0", {16'h0, rk[0]}, {16'h0, 48'h1B02EFFC7072});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
